// File: rtl/example_pkg.sv
// Shared types and constants for the etch-a-sketch demo top.
// Colour encoding: bit 2 = R, bit 1 = G, bit 0 = B.
package example_pkg;

  localparam int unsigned COLOR_WIDTH = 3;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  localparam color_t COLOR_OFF = 3'd0;

  // Metastability guard depth for the raw button inputs.
  localparam int unsigned SYNC_DEPTH = 2;

  // Natural 3-bit overflow gives the 7 -> 0 wrap.
  function automatic color_t color_next(input color_t c);
    return c + color_t'(1);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button debouncer: synchronises one asynchronous button and flips its level only after it has
// held a new value for BOUNCE_TICKS cycles; rise pulses on the same edge as the 0->1 flip.
module debouncer
  import example_pkg::*;
#(
  parameter int unsigned BOUNCE_TICKS = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise
);

  localparam int unsigned CntWidth = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(BOUNCE_TICKS - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], in};
    end
  end

  assign sync = sync_q[SYNC_DEPTH-1];
  assign flip = (sync != level_q) && (cnt_q == CntLast);

  // Any return to the debounced level restarts the count from zero.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d   = '0;
      level_d = sync;
    end else begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = flip & sync;

endmodule

// File: rtl/example_top.sv
// Etch-a-sketch demo top: two debounced buttons step (bit 1) or clear (bit 0) a colour index.
// Define RGB_ACTIVE_LOW_EN to drive common-anode LEDs (rgb inverted, resets to 3'b111).
module example_top
  import example_pkg::*;
#(
  parameter int unsigned BOUNCE_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] buttons,
  output logic [2:0] rgb,
  output logic [1:0] leds
);

  logic   level_clr, rise_clr;
  logic   level_adv, rise_adv;
  color_t color_q, color_d;

  debouncer #(
    .BOUNCE_TICKS(BOUNCE_TICKS)
  ) u_deb_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (buttons[0]),
    .level(level_clr),
    .rise (rise_clr)
  );

  debouncer #(
    .BOUNCE_TICKS(BOUNCE_TICKS)
  ) u_deb_adv (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (buttons[1]),
    .level(level_adv),
    .rise (rise_adv)
  );

  // Clear has priority when both presses land on the same edge.
  always_comb begin
    color_d = color_q;
    if (rise_clr) begin
      color_d = COLOR_OFF;
    end else if (rise_adv) begin
      color_d = color_next(color_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q <= COLOR_OFF;
    end else begin
      color_q <= color_d;
    end
  end

`ifdef RGB_ACTIVE_LOW_EN
  assign rgb = ~color_q;
`else
  assign rgb = color_q;
`endif

  assign leds = {level_adv, level_clr};

endmodule

// File: tb/tb_example_top.sv
// Directed bench for example_top (BOUNCE_TICKS = 50) with an rgb change scoreboard.
module tb_example_top;
  import example_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] buttons;
  logic [2:0] rgb;
  logic [1:0] leds;

  int checks = 0;
  int errors = 0;

  color_t     exp_q[$];
  color_t     model;
  logic [2:0] prev_rgb;
  bit         mon_en = 1'b0;

  example_top #(
    .BOUNCE_TICKS(50)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .buttons(buttons),
    .rgb    (rgb),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_rgb(input color_t c);
`ifdef RGB_ACTIVE_LOW_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rgb change must match the next queued expectation, in order.
  always @(negedge clk) begin
    if (mon_en && (rgb !== prev_rgb)) begin
      if (exp_q.size() == 0) begin
        check("rgb_unexpected", {5'd0, rgb}, {5'd0, prev_rgb});
      end else begin
        check("rgb_sb", {5'd0, rgb}, {5'd0, exp_rgb(exp_q.pop_front())});
      end
      prev_rgb = rgb;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; holds b for hold cycles then idles.
  task automatic drive(input logic [1:0] b, input int hold, input int idle);
    buttons = b;
    wait_neg(hold);
    buttons = 2'b00;
    wait_neg(idle);
  endtask

  task automatic press_adv(input int idle);
    model = color_next(model);
    exp_q.push_back(model);
    drive(2'b10, 100, idle);
  endtask

  initial begin
    model   = COLOR_OFF;
    buttons = 2'b11;
    rst_n   = 1'b0;
    #1;
    check("rst_rgb_t1", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    check("rst_leds_t1", {6'd0, leds}, 8'd0);
    #7;
    check("rst_rgb_mid", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    wait_neg(2);
    check("rst_rgb_end", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    check("rst_leds_end", {6'd0, leds}, 8'd0);
    rst_n    = 1'b1;
    buttons  = 2'b00;
    prev_rgb = rgb;
    mon_en   = 1'b1;
    wait_neg(10);

    // Single press with exact latency on press and release.
    model = color_next(model);
    exp_q.push_back(model);
    buttons = 2'b10;
    wait_neg(51);
    check("press_rgb_early", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    check("press_leds_early", {6'd0, leds}, 8'd0);
    wait_neg(1);
    check("press_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});
    check("press_leds", {6'd0, leds}, 8'h02);
    wait_neg(48);
    buttons = 2'b00;
    wait_neg(51);
    check("rel_leds_early", {6'd0, leds}, 8'h02);
    wait_neg(1);
    check("rel_leds", {6'd0, leds}, 8'd0);
    check("rel_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});
    wait_neg(100);

    // Glitches shorter than BOUNCE_TICKS are rejected.
    drive(2'b10, 30, 100);
    check("glitch30_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});
    check("glitch30_leds", {6'd0, leds}, 8'd0);
    drive(2'b10, 49, 100);
    check("glitch49_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});
    check("glitch49_leds", {6'd0, leds}, 8'd0);

    // Eight presses cross the 7 -> 0 wrap.
    for (int i = 0; i < 8; i++) begin
      press_adv(100 + i * 13);
      check("wrap_rgb", {5'd0, rgb}, {5'd0, exp_rgb(model)});
    end

    // Step to 5, then clear.
    for (int i = 0; i < 4; i++) press_adv(120);
    check("pre_clr_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd5)});
    model = COLOR_OFF;
    exp_q.push_back(model);
    buttons = 2'b01;
    wait_neg(51);
    check("clr_leds_early", {6'd0, leds}, 8'd0);
    check("clr_rgb_early", {5'd0, rgb}, {5'd0, exp_rgb(3'd5)});
    wait_neg(1);
    check("clr_leds", {6'd0, leds}, 8'h01);
    check("clr_rgb", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    wait_neg(48);
    buttons = 2'b00;
    wait_neg(150);

    // Simultaneous rises: clear wins.
    press_adv(120);
    press_adv(120);
    model = COLOR_OFF;
    exp_q.push_back(model);
    buttons = 2'b11;
    wait_neg(52);
    check("both_rgb", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    check("both_leds", {6'd0, leds}, 8'h03);
    wait_neg(48);
    buttons = 2'b00;
    wait_neg(150);

    // Reset mid-press, button held through release of reset.
    press_adv(120);
    buttons = 2'b10;
    wait_neg(20);
    model = COLOR_OFF;
    exp_q.push_back(model);
    rst_n = 1'b0;
    #1;
    check("rstmid_rgb", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    check("rstmid_leds", {6'd0, leds}, 8'd0);
    wait_neg(2);
    rst_n = 1'b1;
    model = color_next(model);
    exp_q.push_back(model);
    wait_neg(51);
    check("rstrel_rgb_early", {5'd0, rgb}, {5'd0, exp_rgb(COLOR_OFF)});
    wait_neg(1);
    check("rstrel_rgb", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});
    check("rstrel_leds", {6'd0, leds}, 8'h02);
    wait_neg(100);
    buttons = 2'b00;
    wait_neg(150);
    check("rstrel_rgb_final", {5'd0, rgb}, {5'd0, exp_rgb(3'd1)});

    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
